// File: rtl/sram_2p_be_if.sv
// sram_2p_be_if: write/read port bundle for sram_2p_be.
// master drives ena, wea, addra, dina, enb and addrb; slave drives doutb, validb and busy.
interface sram_2p_be_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15
);
  localparam int NB = DATA_W / 8;
  logic              ena;
  logic [NB-1:0]     wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic              enb;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] doutb;
  logic              validb;
  logic              busy;
  modport master (output ena, wea, addra, dina, enb, addrb, input doutb, validb, busy);
  modport slave  (input ena, wea, addra, dina, enb, addrb, output doutb, validb, busy);
endinterface

// File: rtl/sram_2p_be.sv
// sram_2p_be: single-clock 1W/1R SRAM with byte enables, write-first collision forwarding,
// optional output register (OUT_REG) and optional post-reset clear sweep (SRAM_2P_BE_CLEAR_EN).
// Ports: clk, rst (sync, active-high); bus (slave): write port ena/wea/addra/dina,
// read port enb/addrb -> doutb/validb, busy high while the clear sweep runs.
module sram_2p_be #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 15,
  parameter int OUT_REG = 0
) (
  input logic         clk,
  input logic         rst,
  sram_2p_be_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              busy, clr_we, wr, rd, v1_q;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] fwd_d, d1_q;
`ifdef SRAM_2P_BE_CLEAR_EN
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else if (state_q == CLEAR) begin
      cnt_q   <= cnt_q + 1'b1;
      state_q <= &cnt_q ? IDLE : CLEAR;
    end
  end
  assign busy     = state_q == CLEAR;
  assign clr_we   = busy & ~rst;
  assign clr_addr = cnt_q;
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif
  assign wr = bus.ena & ~busy & ~rst;
  assign rd = bus.enb & ~busy & ~rst;
  always_ff @(posedge clk) begin
    if (clr_we) mem_q[clr_addr] <= '0;
    else if (wr)
      for (int i = 0; i < NB; i++)
        if (bus.wea[i]) mem_q[bus.addra][8*i +: 8] <= bus.dina[8*i +: 8];
  end
  // Write-first: lanes written in the same cycle at the same address come from dina.
  always_comb begin
    fwd_d = mem_q[bus.addrb];
    for (int i = 0; i < NB; i++)
      fwd_d[8*i +: 8] = (wr && bus.wea[i] && bus.addra == bus.addrb) ? bus.dina[8*i +: 8] : fwd_d[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= rd;
      d1_q <= rd ? fwd_d : d1_q;
    end
  end
  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] d2_q;
    logic              v2_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        d2_q <= v1_q ? d1_q : d2_q;
      end
    end
    assign bus.doutb  = d2_q;
    assign bus.validb = v2_q;
  end else begin : g_noreg
    assign bus.doutb  = d1_q;
    assign bus.validb = v1_q;
  end
  assign bus.busy = busy;
endmodule

// File: tb/tb_sram_2p_be.sv
// tb_sram_2p_be: scoreboard bench driving OUT_REG=0 and OUT_REG=1 instances with identical stimulus.
module tb_sram_2p_be;
  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;
`ifdef SRAM_2P_BE_CLEAR_EN
  localparam int CLR = 1;
`else
  localparam int CLR = 0;
`endif
  logic        clk = 1'b0;
  logic        rst;
  logic        ena, enb;
  logic [3:0]  wea, addra, addrb;
  logic [31:0] dina;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n;
  exp_t        q0[$], q1[$];
  sram_2p_be_if #(.DATA_W(32), .ADDR_W(4)) b0 ();
  sram_2p_be_if #(.DATA_W(32), .ADDR_W(4)) b1 ();
  assign b0.ena = ena;
  assign b0.wea = wea;
  assign b0.addra = addra;
  assign b0.dina = dina;
  assign b0.enb = enb;
  assign b0.addrb = addrb;
  assign b1.ena = ena;
  assign b1.wea = wea;
  assign b1.addra = addra;
  assign b1.dina = dina;
  assign b1.enb = enb;
  assign b1.addrb = addrb;
  sram_2p_be #(.DATA_W(32), .ADDR_W(4), .OUT_REG(0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  sram_2p_be #(.DATA_W(32), .ADDR_W(4), .OUT_REG(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (b0.validb === 1'b1) begin
      if (q0.size() == 0) chk("dut0 unexpected validb", {31'b0, b0.validb}, 32'd0);
      else begin
        e = q0.pop_front();
        chk("dut0 rdata", b0.doutb, e.d);
        chk("dut0 latency", cyc, e.due);
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (b1.validb === 1'b1) begin
      if (q1.size() == 0) chk("dut1 unexpected validb", {31'b0, b1.validb}, 32'd0);
      else begin
        e = q1.pop_front();
        chk("dut1 rdata", b1.doutb, e.d);
        chk("dut1 latency", cyc, e.due);
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] d, input bit to0, input bit to1);
    exp_t e;
    e.d = d;
    e.due = cyc + 1;
    if (to0) q0.push_back(e);
    e.due = cyc + 2;
    if (to1) q1.push_back(e);
  endtask
  task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    ena = 1'b1;
    addra = a;
    wea = be;
    dina = d;
    tick;
    ena = 1'b0;
    wea = '0;
  endtask
  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    enb = 1'b1;
    addrb = a;
    push(e, 1'b1, 1'b1);
    tick;
    enb = 1'b0;
  endtask
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while ((b0.busy | b1.busy) && cnt < 100) begin
      tick;
      cnt++;
    end
  endtask
  task automatic drain;
    repeat (4) tick;
    chk("dut0 queue drained", q0.size(), 32'd0);
    chk("dut1 queue drained", q1.size(), 32'd0);
  endtask
  function automatic logic [31:0] pat(input int a);
    logic [31:0] x;
    x = a;
    return (32'h01010101 * x) ^ 32'hA5000000;
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    ena = 1'b0;
    enb = 1'b0;
    wea = '0;
    addra = '0;
    addrb = '0;
    dina = '0;
    tick;
    tick;
    chk("reset doutb dut0", b0.doutb, 32'd0);
    chk("reset doutb dut1", b1.doutb, 32'd0);
    chk("reset validb dut0", {31'b0, b0.validb}, 32'd0);
    chk("reset validb dut1", {31'b0, b1.validb}, 32'd0);
    chk("reset busy dut0", {31'b0, b0.busy}, CLR);
    rst = 1'b0;
    wait_idle(n);
    chk("initial sweep length", n, CLR * 16);
    wr(4'd3, 4'hF, 32'hDEADBEEF);
    rd(4'd3, 32'hDEADBEEF);
    wr(4'd5, 4'hF, 32'h11223344);
    wr(4'd5, 4'h5, 32'hAABBCCDD);
    rd(4'd5, 32'h11BB33DD);
    wr(4'd7, 4'hF, 32'h00000000);
    ena = 1'b1;
    addra = 4'd7;
    wea = 4'h3;
    dina = 32'hCAFEF00D;
    enb = 1'b1;
    addrb = 4'd7;
    push(32'h0000F00D, 1'b1, 1'b1);
    tick;
    ena = 1'b0;
    enb = 1'b0;
    wea = '0;
    rd(4'd7, 32'h0000F00D);
    wr(4'd3, 4'h0, 32'h00000000);
    rd(4'd3, 32'hDEADBEEF);
    enb = 1'b1;
    addrb = 4'd3;
    push(32'hDEADBEEF, 1'b1, 1'b1);
    tick;
    enb = 1'b0;
    wr(4'd3, 4'hF, 32'h55555555);
    rd(4'd3, 32'h55555555);
    drain;
    for (int a = 0; a < 16; a++) wr(a[3:0], 4'hF, pat(a));
    for (int a = 0; a < 16; a++) begin
      enb = 1'b1;
      addrb = a[3:0];
      push(pat(a), 1'b1, 1'b1);
      tick;
    end
    enb = 1'b0;
    drain;
    chk("held doutb dut0", b0.doutb, pat(15));
    chk("held doutb dut1", b1.doutb, pat(15));
    enb = 1'b1;
    addrb = 4'd2;
    push(pat(2), 1'b1, 1'b0);
    tick;
    enb = 1'b0;
    rst = 1'b1;
    q1.delete();
    tick;
    chk("mid-read rst validb dut0", {31'b0, b0.validb}, 32'd0);
    chk("mid-read rst validb dut1", {31'b0, b1.validb}, 32'd0);
    chk("mid-read rst doutb dut0", b0.doutb, 32'd0);
    chk("mid-read rst doutb dut1", b1.doutb, 32'd0);
    tick;
    chk("post rst validb dut1", {31'b0, b1.validb}, 32'd0);
    rst = 1'b0;
    wait_idle(n);
    drain;
`ifdef SRAM_2P_BE_CLEAR_EN
    wr(4'd9, 4'hF, 32'h12345678);
    rd(4'd9, 32'h12345678);
    rst = 1'b1;
    tick;
    tick;
    chk("busy during rst dut0", {31'b0, b0.busy}, 32'd1);
    chk("busy during rst dut1", {31'b0, b1.busy}, 32'd1);
    rst = 1'b0;
    n = 0;
    addra = 4'd0;
    wea = 4'hF;
    dina = 32'hFFFFFFFF;
    addrb = 4'd9;
    while (b0.busy && n < 100) begin
      ena = n == 5;
      enb = n == 6;
      tick;
      n++;
    end
    ena = 1'b0;
    enb = 1'b0;
    wea = '0;
    chk("sweep length", n, 32'd16);
    chk("busy low dut1", {31'b0, b1.busy}, 32'd0);
    for (int a = 0; a < 16; a++) rd(a[3:0], 32'd0);
    drain;
    wr(4'd9, 4'hF, 32'h12345678);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    repeat (8) tick;
    chk("busy mid-sweep", {31'b0, b0.busy}, 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    wait_idle(n);
    chk("restarted sweep length", n, 32'd16);
    rd(4'd9, 32'd0);
    rd(4'd15, 32'd0);
    drain;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sram_2p_be.md
# sram_2p_be

Parametrised single-clock two-port SRAM (one write port, one read port) with per-byte write enables, write-first collision forwarding, an optional output pipeline register and an optional post-reset clear engine. It replaces the fixed 32kx32 buffer memories in the NPU datapath, such as weight, activation and partial-sum buffers, wherever a synchronous-reset, single-clock-domain buffer is needed.

## Interface
- DATA_W, 32, data width in bits; must be a multiple of 8; NB = DATA_W/8 byte lanes
- ADDR_W, 15, address width; DEPTH = 2**ADDR_W words
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- ena  in  1  write port enable
- wea  in  NB  byte write enables; bit i covers dina[8i+7:8i]
- addra  in  ADDR_W  write address
- dina  in  DATA_W  write data
- enb  in  1  read enable
- addrb  in  ADDR_W  read address
- doutb  out  DATA_W  read data
- validb  out  1  one-cycle strobe; doutb carries new read data
- busy  out  1  clear engine active; both ports ignored while high

## Operation
- Write: when ena=1, wea!=0 and busy=0, lanes with wea[i]=1 update mem[addra]; other lanes keep their contents. When ena=1 and wea=0, nothing is written.
- Read: when enb=1 and busy=0, addrb is accepted. Data returns after the read latency with validb=1 for one cycle.
- doutb holds its last value between reads. It does not return to 0 when enb=0.
- Collision: a write and a read to the same address in the same cycle return merged write-first data. Lanes with wea[i]=1 return dina; all other lanes return the old memory contents.
- Write after read: a write in cycle N+1 does not alter a read accepted in cycle N. The read returns the pre-write data for both OUT_REG settings.
- Back-to-back reads are supported at one per cycle and return in order, with no bubbles.
- Reset values: doutb=0, validb=0, pipeline stage=0. busy is as defined in Configuration.
- Memory array contents are not reset, except by the clear engine.
- Reset mid-operation: reads in flight are discarded, so no validb is produced for them. A write in the same cycle as rst=1 is ignored.

## Timing
- OUT_REG=0: read accepted at edge N; doutb and validb valid after edge N+1.
- OUT_REG=1: read accepted at edge N; doutb and validb valid after edge N+2.
- Write accepted at edge N is visible to a read accepted at edge N (forwarding) or at any later edge.
- No combinational path exists from any input to doutb or validb. Outputs are registered.

## Configuration
- Macro: SRAM_2P_BE_CLEAR_EN.
- Defined: a two-state FSM, CLEAR and IDLE, with an ADDR_W-bit counter.
  - rst=1 forces state CLEAR and counter 0. Inside CLEAR, writes are blocked.
  - Each cycle in CLEAR writes 0 to mem[counter] and increments the counter.
  - When counter=DEPTH-1 is written, the FSM moves to IDLE.
  - busy=1 in CLEAR, including during rst, and 0 in IDLE.
  - After rst falls, busy stays high for exactly DEPTH cycles.
  - rst asserted mid-clear restarts the sweep at address 0.
  - Read and write requests presented while busy=1 are dropped, not queued.
- Not defined: no FSM or counter. busy is tied to 0. Memory powers up undefined (X in simulation). Ports are usable from the first cycle after rst falls.

## Test plan
Use DATA_W=32, ADDR_W=4 and both OUT_REG values.
- Basic read: write 0xDEADBEEF to address 3 with wea=0xF, then read address 3 -> doutb=0xDEADBEEF with validb at latency 1 or 2, matching OUT_REG.
- Byte enables: write 0x11223344 to address 5 with wea=0xF, then write 0xAABBCCDD to address 5 with wea=0x5, then read address 5 -> 0x11BB33DD.
- Same-address collision: address 7 holds 0x00000000. In the same cycle, write 0xCAFEF00D to address 7 with wea=0x3 and read address 7 -> 0x0000F00D.
- Streaming reads: read addresses 0..15 on consecutive cycles -> 16 consecutive validb pulses, data in address order, no gaps, doutb held afterwards.
- Reset mid-read: accept a read and assert rst the next cycle -> validb=0 and doutb=0 from the reset edge on; no stale strobe follows.
- With SRAM_2P_BE_CLEAR_EN:
  - Preload address 9 with 0x12345678, then pulse rst -> busy high for 16 cycles after rst falls.
  - A write issued during busy is dropped.
  - Afterwards, reads of every address return 0.
  - Re-asserting rst at sweep address 8 restarts the 16-cycle sweep from address 0.
